// File: rtl/snn_pkg.sv
`default_nettype none
// ==========================================================================
// snn_pkg : FSM encoding and saturating/leak arithmetic for the LIF layer
// Rev 1.0
// ==========================================================================
package snn_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FIRE  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Add two sign-extended values and clamp to a signed field of `bits` width.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int bits);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (bits - 1)) - 33'sd1;
    lo = -hi - 33'sd1;
    if (s > hi)      return 32'(hi);
    else if (s < lo) return 32'(lo);
    else             return 32'(s);
  endfunction

  function automatic logic signed [31:0] leak(input logic signed [31:0] v,
                                              input int shift);
    return v - (v >>> shift);
  endfunction

endpackage
`default_nettype wire

// File: rtl/snn_lif_layer_if.sv
`default_nettype none
// ==========================================================================
// snn_lif_layer_if : input spike stream and output spike stream handshakes
// Rev 1.0
// ==========================================================================
interface snn_lif_layer_if #(
  parameter int N_IN   = 12,
  parameter int N_NEUR = 32
);
  logic [N_IN-1:0]   s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;
  logic [N_NEUR-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface
`default_nettype wire

// File: rtl/lif_neuron.sv
`default_nettype none
// ==========================================================================
// lif_neuron : one leaky integrate-and-fire membrane with saturating spike count
// Rev 1.0
// ==========================================================================
module lif_neuron
  import snn_pkg::*;
#(
  parameter int W_BITS   = 8,
  parameter int V_BITS   = 16,
  parameter int CNT_BITS = 16,
  parameter int TH       = 64,
  parameter int LEAK     = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  input  wire logic                       i_clear,
  input  wire logic                       i_zero_v,
  input  wire logic                       i_clr_cnt,
  input  wire logic                       i_add,
  input  wire logic signed [W_BITS-1:0]   i_w,
  input  wire logic                       i_fire,
  input  wire logic                       i_sub_reset,
  output logic                            o_spike,
  output logic [CNT_BITS-1:0]             o_cnt
);

  logic signed [V_BITS-1:0] r_v;
  logic [CNT_BITS-1:0]      r_cnt;
  logic signed [31:0]       w_vl;

  assign w_vl    = leak(32'(r_v), LEAK);
  assign o_spike = (w_vl >= TH);
  assign o_cnt   = r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear || i_zero_v) begin
      r_v <= '0;
    end else if (i_add) begin
      r_v <= V_BITS'(sat_add(32'(r_v), 32'(i_w), V_BITS));
    end else if (i_fire) begin
      if (o_spike) r_v <= i_sub_reset ? V_BITS'(w_vl - TH) : '0;
      else         r_v <= V_BITS'(w_vl);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear || i_clr_cnt) begin
      r_cnt <= '0;
    end else if (i_fire && o_spike && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_BITS'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/snn_lif_layer.sv
`default_nettype none
// ==========================================================================
// snn_lif_layer : fully connected LIF layer, one spike-mask beat per timestep
// Rev 1.0
// ==========================================================================
module snn_lif_layer
  import snn_pkg::*;
#(
  parameter int N_IN     = 12,
  parameter int N_NEUR   = 32,
  parameter int W_BITS   = 8,
  parameter int V_BITS   = 16,
  parameter int CNT_BITS = 16,
  parameter int TH       = 64,
  parameter int LEAK     = 4
) (
  input  wire logic                       s00_axi_aclk,
  input  wire logic                       s00_axi_aresetn,
  snn_lif_layer_if.slave                  axis,
  input  wire logic                       w_we,
  input  wire logic [$clog2(N_IN)-1:0]    w_addr,
  input  wire logic [N_NEUR*W_BITS-1:0]   w_data,
  input  wire logic                       cfg_sub_reset,
  input  wire logic                       clear,
  input  wire logic [$clog2(N_NEUR)-1:0]  cnt_sel,
  output logic [CNT_BITS-1:0]             cnt_out,
  output logic                            busy
);

  localparam int IDX_W = $clog2(N_IN);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [IDX_W-1:0]         r_idx;
  logic [N_IN-1:0]          r_mask;
  logic                     r_last;
  logic [N_NEUR-1:0]        r_tdata;
  logic                     r_tlast;
  logic                     r_win_done;
  logic [N_NEUR*W_BITS-1:0] r_w [N_IN];
  logic [N_NEUR-1:0]        w_spike;
  logic [CNT_BITS-1:0]      w_cnt [N_NEUR];
  logic                     w_acc;
  logic                     w_out_hs;
  logic                     w_add;

  assign axis.s_axis_tready = (r_state == S_IDLE) && s00_axi_aresetn;
  assign axis.m_axis_tvalid = (r_state == S_OUT);
  assign axis.m_axis_tdata  = r_tdata;
  assign axis.m_axis_tlast  = r_tlast;
  assign busy               = (r_state != S_IDLE);
  assign cnt_out            = w_cnt[cnt_sel];

  assign w_acc    = axis.s_axis_tvalid && axis.s_axis_tready && !clear;
  assign w_out_hs = (r_state == S_OUT) && axis.m_axis_tready && !clear;
  assign w_add    = (r_state == S_ACCUM) && r_mask[r_idx];

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) r_state <= S_IDLE;
    else                  r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_acc) w_state_nxt = S_ACCUM;
        S_ACCUM: if (r_idx == IDX_W'(N_IN - 1)) w_state_nxt = S_FIRE;
        S_FIRE:  w_state_nxt = S_OUT;
        S_OUT:   if (axis.m_axis_tready) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Window bookkeeping: counters survive the last output beat and are
  // wiped only when the next window's first beat arrives.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_idx      <= '0;
      r_mask     <= '0;
      r_last     <= 1'b0;
      r_tdata    <= '0;
      r_tlast    <= 1'b0;
      r_win_done <= 1'b0;
    end else begin
      if (w_acc) begin
        r_mask     <= axis.s_axis_tdata;
        r_last     <= axis.s_axis_tlast;
        r_idx      <= '0;
        r_win_done <= 1'b0;
      end
      if (r_state == S_ACCUM) r_idx <= r_idx + IDX_W'(1);
      if ((r_state == S_FIRE) && !clear) begin
        r_tdata <= w_spike;
        r_tlast <= r_last;
      end
      if (w_out_hs && r_tlast) r_win_done <= 1'b1;
      if (clear)               r_win_done <= 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      for (int i = 0; i < N_IN; i++) r_w[i] <= '0;
    end else if (w_we && (r_state == S_IDLE) && (int'(w_addr) < N_IN)) begin
      r_w[w_addr] <= w_data;
    end
  end

  for (genvar j = 0; j < N_NEUR; j++) begin : g_neur
    lif_neuron #(
      .W_BITS   (W_BITS),
      .V_BITS   (V_BITS),
      .CNT_BITS (CNT_BITS),
      .TH       (TH),
      .LEAK     (LEAK)
    ) u_neuron (
      .clk         (s00_axi_aclk),
      .rst_n       (s00_axi_aresetn),
      .i_clear     (clear),
      .i_zero_v    (w_out_hs && r_tlast),
      .i_clr_cnt   (w_acc && r_win_done),
      .i_add       (w_add),
      .i_w         (r_w[r_idx][j*W_BITS +: W_BITS]),
      .i_fire      (r_state == S_FIRE),
      .i_sub_reset (cfg_sub_reset),
      .o_spike     (w_spike[j]),
      .o_cnt       (w_cnt[j])
    );
  end

endmodule
`default_nettype wire
